// File: rtl/hwag_pkg.sv
// hwag_pkg -- shared constants and types for the crank-angle generator front end.
//
// Contents:
//   EDGE_RISE / EDGE_FALL   values of the edge_sel input
//   HWAG_WIDTH              default period timer / capture register width
//   HWAG_FILT_WIDTH         default glitch-filter length width
//   cap_cnt_t               count of real periods held in the capture history
package hwag_pkg;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  localparam int HWAG_WIDTH      = 24;
  localparam int HWAG_FILT_WIDTH = 4;

  typedef logic [1:0] cap_cnt_t;

  // History is full once three real periods have been shifted in.
  localparam cap_cnt_t CAP_CNT_FULL = 2'd3;

endpackage

// File: rtl/hwag_edge_filter.sv
// hwag_edge_filter -- synchroniser, glitch filter and edge detector for the
// tooth sensor input.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ena_i           prescaler tick; the filter only advances when high
//   cap_i           raw asynchronous tooth sensor input
//   edge_sel_i      EDGE_RISE / EDGE_FALL, which filtered toggle is accepted
//   filt_len_i      consecutive ena samples needed to accept a level change
//   level_o         filtered level
//   edge_o          one-cycle pulse (combinational) in the accepting cycle
module hwag_edge_filter
  import hwag_pkg::*;
#(
  parameter int FILT_WIDTH = HWAG_FILT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_i,
  input  logic                  cap_i,
  input  logic                  edge_sel_i,
  input  logic [FILT_WIDTH-1:0] filt_len_i,
  output logic                  level_o,
  output logic                  edge_o
);

  localparam logic [FILT_WIDTH:0] CNT_ONE = {{FILT_WIDTH{1'b0}}, 1'b1};

  logic                  sync1_q, sync2_q;
  logic                  level_q, level_d;
  logic [FILT_WIDTH-1:0] cnt_q, cnt_d;
  logic [FILT_WIDTH:0]   len_eff;
  logic [FILT_WIDTH:0]   cnt_inc;
  logic                  toggle;

  always_comb begin
    // A length of zero is treated as one sample.
    len_eff = (filt_len_i == '0) ? CNT_ONE : {1'b0, filt_len_i};
    // One bit wider so the compare cannot wrap at the maximum length.
    cnt_inc = {1'b0, cnt_q} + CNT_ONE;
    toggle  = ena_i && (sync2_q != level_q) && (cnt_inc >= len_eff);

    cnt_d   = cnt_q;
    level_d = level_q;
    if (ena_i) begin
      if ((sync2_q == level_q) || toggle) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc[FILT_WIDTH-1:0];
      end
      if (toggle) begin
        level_d = ~level_q;
      end
    end

    // The new filtered level equals sync2_q; accept it only in the chosen direction.
    edge_o = toggle && ((edge_sel_i == EDGE_RISE) ? sync2_q : ~sync2_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= cap_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/hwag_capture.sv
// hwag_capture -- tooth period measurement with a three-deep history.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ena             prescaler tick; timer and filter advance only when high
//   cap_in          raw asynchronous tooth sensor input
//   edge_sel        0 = capture on rising edge, 1 = capture on falling edge
//   filt_len        glitch-filter length in ena samples (0 acts as 1)
//   tcnt            ticks since the last accepted edge (saturating)
//   cap0/cap1/cap2  newest / previous / oldest captured period
//   cap_strobe      one-cycle pulse in the cycle the history shifts
//   cap_valid       all three captures hold real periods
//   stall           timer saturated or no reference edge yet
module hwag_capture
  import hwag_pkg::*;
#(
  parameter int WIDTH      = HWAG_WIDTH,
  parameter int FILT_WIDTH = HWAG_FILT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  cap_in,
  input  logic                  edge_sel,
  input  logic [FILT_WIDTH-1:0] filt_len,
  output logic [WIDTH-1:0]      tcnt,
  output logic [WIDTH-1:0]      cap0,
  output logic [WIDTH-1:0]      cap1,
  output logic [WIDTH-1:0]      cap2,
  output logic                  cap_strobe,
  output logic                  cap_valid,
  output logic                  stall
);

  localparam logic [WIDTH-1:0] TMAX = '1;
  localparam logic [WIDTH-1:0] TONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             edge_acc;
  // Filtered level is not needed for period measurement.
  logic             filt_level_unused;

  logic [WIDTH-1:0] tcnt_q, tcnt_d;
  logic [WIDTH-1:0] cap0_q, cap0_d, cap1_q, cap1_d, cap2_q, cap2_d;
  logic             strobe_q, strobe_d;
  logic             valid_q, valid_d;
  logic             stall_q, stall_d;
  cap_cnt_t         vcnt_q, vcnt_d;
  logic [WIDTH-1:0] tcnt_inc;

  hwag_edge_filter #(
    .FILT_WIDTH (FILT_WIDTH)
  ) u_edge_filter (
    .clk        (clk),
    .rst        (rst),
    .ena_i      (ena),
    .cap_i      (cap_in),
    .edge_sel_i (edge_sel),
    .filt_len_i (filt_len),
    .level_o    (filt_level_unused),
    .edge_o     (edge_acc)
  );

  always_comb begin
    // Saturating tcnt+1: both the next timer value and the captured period.
    tcnt_inc = (tcnt_q == TMAX) ? TMAX : (tcnt_q + TONE);

    tcnt_d   = tcnt_q;
    cap0_d   = cap0_q;
    cap1_d   = cap1_q;
    cap2_d   = cap2_q;
    stall_d  = stall_q;
    vcnt_d   = vcnt_q;
    strobe_d = 1'b0;

    // edge_acc is only ever high on an ena cycle, and it wins over saturation.
    if (edge_acc) begin
      tcnt_d = '0;
      if (stall_q) begin
        // This edge only becomes the reference for the next period.
        stall_d = 1'b0;
      end else begin
        cap2_d   = cap1_q;
        cap1_d   = cap0_q;
        cap0_d   = tcnt_inc;
        strobe_d = 1'b1;
        vcnt_d   = (vcnt_q == CAP_CNT_FULL) ? vcnt_q : (vcnt_q + 2'd1);
      end
    end else if (ena) begin
      tcnt_d = tcnt_inc;
      if (tcnt_inc == TMAX) begin
        stall_d = 1'b1;
        cap0_d  = '0;
        cap1_d  = '0;
        cap2_d  = '0;
        vcnt_d  = '0;
      end
    end

    valid_d = (vcnt_d == CAP_CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q   <= '0;
      cap0_q   <= '0;
      cap1_q   <= '0;
      cap2_q   <= '0;
      strobe_q <= 1'b0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b1;
      vcnt_q   <= '0;
    end else begin
      tcnt_q   <= tcnt_d;
      cap0_q   <= cap0_d;
      cap1_q   <= cap1_d;
      cap2_q   <= cap2_d;
      strobe_q <= strobe_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
      vcnt_q   <= vcnt_d;
    end
  end

  assign tcnt       = tcnt_q;
  assign cap0       = cap0_q;
  assign cap1       = cap1_q;
  assign cap2       = cap2_q;
  assign cap_strobe = strobe_q;
  assign cap_valid  = valid_q;
  assign stall      = stall_q;

endmodule

// File: doc/hwag_capture.md
Name: hwag_capture

Overview:
- Front end of the crank-angle generator.
- Synchronises and deglitches the tooth sensor input, then measures the period between qualified edges in prescaled timer ticks.
- Keeps a three-deep period history: cap0 is the newest period, cap1 the previous one, cap2 the oldest.
- Feeds the downstream period-window check, gap detection and timer-compare-reload logic directly.

Parameters:
- WIDTH, 24, width of the period timer and of each capture register.
- FILT_WIDTH, 4, width of the glitch-filter length input and filter counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous and active-high
- ena  in  1  prescaler tick; the timer and filter advance only when ena=1
- cap_in  in  1  raw tooth sensor input, asynchronous
- edge_sel  in  1  0 = capture on rising edge, 1 = capture on falling edge
- filt_len  in  FILT_WIDTH  consecutive ena samples needed to accept a level change
- tcnt  out  WIDTH  running tick count since the last accepted edge
- cap0  out  WIDTH  newest captured period
- cap1  out  WIDTH  previous period
- cap2  out  WIDTH  oldest period
- cap_strobe  out  1  one-cycle pulse in the cycle cap0..cap2 update
- cap_valid  out  1  high when all three captures hold real periods
- stall  out  1  timer saturated; engine considered stopped

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - tcnt, cap0..cap2, cap_strobe, cap_valid and the valid count all clear to 0.
  - stall is set to 1, meaning no reference edge exists yet.
  - Filtered level is set to 0 and the synchroniser flops clear to 0.
  - Reset mid-operation discards history immediately; the next cycle behaves exactly as after power-up.
- Synchroniser: two flops on every clk, independent of ena.
- Filter:
  - On each ena cycle, if the synchronised level differs from the filtered level, the filter counter increments; otherwise it clears.
  - When the count reaches max(filt_len,1), the filtered level toggles and the counter clears.
  - filt_len=0 behaves as 1.
- Accepted edge: a filtered-level toggle in the direction selected by edge_sel. It can only occur on an ena cycle.
- Latency: a clean cap_in transition is accepted after 2 clk of sync delay plus filt_len ena ticks. The capture registers and cap_strobe update on the clk edge of the accepting cycle.
- Timer: on each ena cycle without an accepted edge, tcnt <= tcnt+1, saturating at all-ones.
- On an accepted edge, per = sat(tcnt+1), then:
  - If stall=0: cap2<=cap1, cap1<=cap0, cap0<=per; cap_strobe=1; valid count increments, saturating at 3.
  - If stall=1: no shift and no strobe; stall<=0.
  - In both cases tcnt<=0.
- Saturation: when tcnt reaches all-ones with no edge in that cycle:
  - stall<=1, cap0..cap2<=0, valid count<=0.
  - tcnt holds at all-ones.
- Simultaneous saturation and accepted edge: the edge wins. The capture is taken with per = all-ones and stall is not set.
- cap_valid = (valid count == 3), registered.
- edge_sel changing mid-run takes effect at the next filtered toggle. The filtered level itself is unaffected.
- ena=0 freezes the timer and filter; the synchroniser keeps running.

Decomposition:
- hwag_pkg holds:
  - edge-select constants EDGE_RISE=0 and EDGE_FALL=1;
  - the default WIDTH and FILT_WIDTH values;
  - a 2-bit capture-count typedef.
- One sub-module, hwag_edge_filter: synchroniser plus glitch filter plus edge detect. It outputs a one-cycle accepted-edge pulse and the filtered level.

Test Plan:
- Reset, then edges every 10 ena ticks with filt_len=2, ena always 1:
  - first edge only clears stall;
  - next three edges each strobe with cap0=10;
  - cap_valid rises on the third strobe; cap2=cap1=cap0=10.
- Missing-tooth pattern with periods 10,10,30,10:
  - after the last strobe, cap0=10, cap1=30, cap2=10;
  - downstream gap condition (cap0 and cap2 below cap1/2) holds.
- 1-tick glitch on cap_in with filt_len=3 → no accepted edge, tcnt keeps counting, no strobe.
- WIDTH=8 with no edges for 255 ticks → tcnt=255, stall=1, captures 0, cap_valid=0. The next edge produces no strobe and clears stall.
- ena asserted every 4th clk with edges 5 ena ticks apart → cap0=5. tcnt holds between ena pulses.
- Assert rst mid-sequence after cap_valid=1:
  - next cycle: all captures 0, stall=1, cap_valid=0;
  - three further edges after the reference edge are needed to regain cap_valid.
